// File: rtl/riscv_pkg.sv
// riscv_pkg: ALU op encodings and execute-stage payload; ALU_EXEC_FLAGS_EN adds carry/overflow/negative
package riscv_pkg;
    localparam int PKG_XLEN = 32;
    localparam int PKG_REG_ADDR_W = 5;
    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR} alu_ops_t;
    typedef struct packed {
        logic [PKG_XLEN-1:0]       result;
        logic [PKG_REG_ADDR_W-1:0] rd_addr;
        logic                      reg_write;
        logic                      zero;
`ifdef ALU_EXEC_FLAGS_EN
        logic                      carry;
        logic                      overflow;
        logic                      negative;
`endif
    } exec_payload_t;
endpackage

// File: rtl/alu_exec_stage_core.sv
// alu_core: combinational ADD/SUB/AND/OR/XOR; flag outputs only with ALU_EXEC_FLAGS_EN
module alu_core
    import riscv_pkg::*;
#(
    parameter int XLEN = PKG_XLEN
) (
    input  alu_ops_t          alu_ctrl,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   result
`ifdef ALU_EXEC_FLAGS_EN
    ,
    output logic              carry,
    output logic              overflow,
    output logic              negative
`endif
);
    logic            is_sub;
    logic [XLEN-1:0] bb;
    logic [XLEN:0]   sum;
    always_comb begin
        is_sub = alu_ctrl == ALU_SUB;
        bb     = is_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, bb} + (XLEN+1)'(is_sub);
        result = alu_ctrl == ALU_AND ? a & b :
                 alu_ctrl == ALU_OR  ? a | b :
                 alu_ctrl == ALU_XOR ? a ^ b : sum[XLEN-1:0];
    end
`ifdef ALU_EXEC_FLAGS_EN
    logic arith;
    always_comb begin
        arith    = !(alu_ctrl == ALU_AND || alu_ctrl == ALU_OR || alu_ctrl == ALU_XOR);
        carry    = arith && sum[XLEN];
        overflow = arith && (a[XLEN-1] == bb[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
        negative = result[XLEN-1];
    end
`endif
endmodule

// File: rtl/alu_exec_stage.sv
// alu_exec_stage: registered ALU execute stage with main+skid output buffer; ALU_EXEC_FLAGS_EN adds flag outputs
module alu_exec_stage
    import riscv_pkg::*;
#(
    parameter int XLEN       = PKG_XLEN,
    parameter int REG_ADDR_W = PKG_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  alu_ops_t              alu_ctrl,
    input  logic [XLEN-1:0]       src_a,
    input  logic [XLEN-1:0]       src_b,
    input  logic [REG_ADDR_W-1:0] rd_addr,
    input  logic                  reg_write,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [XLEN-1:0]       alu_result,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic                  out_reg_write,
    output logic                  zero
`ifdef ALU_EXEC_FLAGS_EN
    ,
    output logic                  carry,
    output logic                  overflow,
    output logic                  negative
`endif
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;
    buf_state_t      state, state_nxt;
    exec_payload_t   main_q, skid_q, new_p;
    logic [XLEN-1:0] result;
    logic            accept, xfer;
`ifdef ALU_EXEC_FLAGS_EN
    logic            carry_c, overflow_c, negative_c;
`endif
    alu_core #(.XLEN(XLEN)) u_core (
        .alu_ctrl (alu_ctrl),
        .a        (src_a),
        .b        (src_b),
        .result   (result)
`ifdef ALU_EXEC_FLAGS_EN
        ,
        .carry    (carry_c),
        .overflow (overflow_c),
        .negative (negative_c)
`endif
    );
    always_comb begin
        accept = in_valid && in_ready;
        xfer   = out_valid && out_ready;
        new_p           = '0;
        new_p.result    = result;
        new_p.rd_addr   = rd_addr;
        new_p.reg_write = reg_write;
        new_p.zero      = result == '0;
`ifdef ALU_EXEC_FLAGS_EN
        new_p.carry     = carry_c;
        new_p.overflow  = overflow_c;
        new_p.negative  = negative_c;
`endif
        state_nxt = state == EMPTY ? (accept ? ONE : EMPTY) :
                    state == ONE   ? (accept && !xfer ? TWO : xfer && !accept ? EMPTY : ONE) :
                                     (xfer ? ONE : TWO);
    end
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_q    <= '0;
            skid_q    <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= state_nxt != EMPTY;
            in_ready  <= state_nxt != TWO;
            if (state == TWO && xfer)
                main_q <= skid_q;
            else if (accept && (state == EMPTY || xfer))
                main_q <= new_p;
            if (accept && state == ONE && !xfer)
                skid_q <= new_p;
        end
    end
    assign alu_result    = main_q.result;
    assign out_rd_addr   = main_q.rd_addr;
    assign out_reg_write = main_q.reg_write;
    assign zero          = main_q.zero;
`ifdef ALU_EXEC_FLAGS_EN
    assign carry         = main_q.carry;
    assign overflow      = main_q.overflow;
    assign negative      = main_q.negative;
`endif
endmodule

// File: tb/tb_alu_exec_stage.sv
// tb_alu_exec_stage: table vectors, corner sequences and random traffic against a queue reference model
module tb_alu_exec_stage;
    import riscv_pkg::*;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, reg_write, flush, out_valid, out_ready, out_reg_write, zero;
    alu_ops_t    alu_ctrl;
    logic [31:0] src_a, src_b, alu_result;
    logic [4:0]  rd_addr, out_rd_addr;
`ifdef ALU_EXEC_FLAGS_EN
    logic        carry, overflow, negative;
`endif
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    alu_exec_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_ctrl(alu_ctrl),
        .src_a(src_a), .src_b(src_b), .rd_addr(rd_addr), .reg_write(reg_write), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_result(alu_result),
        .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write), .zero(zero)
`ifdef ALU_EXEC_FLAGS_EN
        , .carry(carry), .overflow(overflow), .negative(negative)
`endif
    );

    typedef struct { logic [31:0] res; logic [4:0] rd; logic rw, c, v, n; } item_t;
    typedef struct { logic [2:0] op; logic [31:0] a, b, res; logic [4:0] rd; logic rw, z, c, v, n; } vec_t;
    item_t       q[$];
    logic [31:0] emitted[$];
    logic        last_acc;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic item_t ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] rd, input logic rw);
        item_t   it;
        longint  sa, sb, s;
        longint unsigned u;
        sa = $signed(a);
        sb = $signed(b);
        it.rd = rd; it.rw = rw; it.c = 0; it.v = 0;
        case (op)
            3'd1: begin
                it.res = a - b;
                it.c   = a >= b;
                s      = sa - sb;
                it.v   = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
            3'd2: it.res = a & b;
            3'd3: it.res = a | b;
            3'd4: it.res = a ^ b;
            default: begin
                u      = {32'b0, a} + {32'b0, b};
                it.res = a + b;
                it.c   = u > 64'hFFFF_FFFF;
                s      = sa + sb;
                it.v   = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
        endcase
        it.n = it.res[31];
        return it;
    endfunction

    task automatic cmp_model();
        chk("out_valid", out_valid, q.size() > 0);
        chk("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            chk("alu_result", alu_result, q[0].res);
            chk("out_rd_addr", out_rd_addr, q[0].rd);
            chk("out_reg_write", out_reg_write, q[0].rw);
            chk("zero", zero, q[0].res == 0);
`ifdef ALU_EXEC_FLAGS_EN
            chk("carry", carry, q[0].c);
            chk("overflow", overflow, q[0].v);
            chk("negative", negative, q[0].n);
`endif
        end
    endtask

    // Drive one cycle of inputs, advance the reference queue at the edge, compare at the next negedge.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input logic rw, input logic ordy, input logic fl, input logic r);
        logic acc, xf;
        in_valid = v; alu_ctrl = alu_ops_t'(op); src_a = a; src_b = b;
        rd_addr = rd; reg_write = rw; out_ready = ordy; flush = fl; rst = r;
        if (out_valid && ordy && !r) emitted.push_back(alu_result);
        @(posedge clk);
        acc = v && q.size() < 2;
        xf  = q.size() > 0 && ordy;
        last_acc = acc && !r && !fl;
        if (r) q.delete();
        else begin
            if (xf) void'(q.pop_front());
            if (fl) q.delete();
            else if (acc) q.push_back(ref_op(op, a, b, rd, rw));
        end
        @(negedge clk);
        cmp_model();
    endtask

    task automatic idle(input logic ordy);
        step(0, 3'd0, 0, 0, 0, 0, ordy, 0, 0);
    endtask

    initial begin
        vec_t tbl[11];
        int   n, cyc;
        logic tog;
        tbl[0]  = '{3'd0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 5'd1,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[1]  = '{3'd1, 32'h5,         32'h5,         32'h0,         5'd3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{3'd2, 32'hF0F0,      32'hFF00,      32'hF000,      5'd4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{3'd4, 32'hFF,        32'h0F,        32'hF0,        5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{3'd3, 32'h1,         32'h2,         32'h3,         5'd6,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{3'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[6]  = '{3'd1, 32'h0,         32'h1,         32'hFFFF_FFFF, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{3'd1, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 5'd9,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8]  = '{3'd5, 32'h2,         32'h3,         32'h5,         5'd10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{3'd7, 32'h8000_0000, 32'h8000_0000, 32'h0,         5'd31, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[10] = '{3'd2, 32'h0,         32'hDEAD_BEEF, 32'h0,         5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        in_valid = 0; alu_ctrl = ALU_ADD; src_a = 0; src_b = 0; rd_addr = 0; reg_write = 0;
        out_ready = 0; flush = 0; rst = 1;
        @(negedge clk);
        step(0, 3'd0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 3'd0, 0, 0, 0, 0, 0, 0, 1);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_result", alu_result, 0);
        chk("reset_rd", out_rd_addr, 0);
        chk("reset_rw", out_reg_write, 0);
        chk("reset_zero", zero, 0);

        for (int i = 0; i < 11; i++) begin
            step(1, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].rd, tbl[i].rw, 1, 0, 0);
            chk("vec_valid", out_valid, 1);
            chk("vec_result", alu_result, tbl[i].res);
            chk("vec_zero", zero, tbl[i].z);
            chk("vec_rd", out_rd_addr, tbl[i].rd);
            chk("vec_rw", out_reg_write, tbl[i].rw);
`ifdef ALU_EXEC_FLAGS_EN
            chk("vec_carry", carry, tbl[i].c);
            chk("vec_overflow", overflow, tbl[i].v);
            chk("vec_negative", negative, tbl[i].n);
`endif
            idle(1);
        end

        step(1, 3'd2, 32'hF0F0, 32'hFF00, 5'd1, 1, 0, 0, 0);
        chk("stall_ready1", in_ready, 1);
        step(1, 3'd4, 32'hFF, 32'h0F, 5'd2, 1, 0, 0, 0);
        chk("stall_ready2", in_ready, 0);
        chk("stall_hold1", alu_result, 32'hF000);
        idle(0);
        chk("stall_hold2", alu_result, 32'hF000);
        idle(1);
        chk("drain_second", alu_result, 32'hF0);
        chk("drain_ready", in_ready, 1);
        idle(1);
        chk("drain_empty", out_valid, 0);

        step(1, 3'd0, 1, 1, 5'd1, 1, 0, 0, 0);
        step(1, 3'd0, 2, 2, 5'd2, 1, 0, 0, 0);
        step(1, 3'd3, 1, 2, 5'd3, 1, 0, 1, 0);
        chk("flush_two_valid", out_valid, 0);
        chk("flush_two_ready", in_ready, 1);
        step(1, 3'd0, 5, 5, 5'd4, 1, 0, 0, 0);
        step(1, 3'd3, 1, 2, 5'd5, 1, 0, 1, 0);
        chk("flush_one_valid", out_valid, 0);
        idle(1);
        idle(1);
        chk("flush_no_or", out_valid, 0);

        step(1, 3'd0, 3, 4, 5'd6, 1, 0, 0, 0);
        step(1, 3'd0, 9, 9, 5'd7, 1, 1, 0, 1);
        chk("rst_one_valid", out_valid, 0);
        chk("rst_one_result", alu_result, 0);
        chk("rst_one_rd", out_rd_addr, 0);
        chk("rst_one_rw", out_reg_write, 0);
        chk("rst_one_zero", zero, 0);
        idle(1);
        idle(1);
        chk("rst_one_quiet", out_valid, 0);

        emitted.delete();
        n = 0; cyc = 0; tog = 0;
        while ((n < 8 || q.size() > 0) && cyc < 100) begin
            tog = !tog;
            if (n < 8) step(1, 3'd0, 32'(n), 32'(n), 5'(n), 1, tog, 0, 0);
            else idle(tog);
            if (last_acc) n++;
            cyc++;
        end
        if (cyc >= 100) chk("stream_timeout", 1, 0);
        idle(1);
        chk("stream_count", emitted.size(), 8);
        for (int k = 0; k < emitted.size() && k < 8; k++) chk("stream_order", emitted[k], 32'(2 * k));

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(3, 0) != 0, 3'($urandom_range(7, 0)),
                 ($urandom_range(3, 0) == 0) ? 32'($urandom_range(4, 0)) : $urandom,
                 ($urandom_range(3, 0) == 0) ? 32'($urandom_range(4, 0)) : $urandom,
                 5'($urandom_range(31, 0)), 1'($urandom_range(1, 0)),
                 $urandom_range(2, 0) != 0, $urandom_range(39, 0) == 0, $urandom_range(96, 0) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_exec_stage.md
Name: alu_exec_stage

Overview:
- Registered execute stage sitting directly downstream of the ALU control decode.
- Consumes `alu_ctrl` plus two operands and a destination tag.
- Computes the ALU result and delivers it to the memory/writeback side over a valid/ready handshake.
- A 2-entry output buffer (main register plus skid register) lets downstream stall without a combinational `ready` path back to decode.

Parameters:
- XLEN, 32, operand/result width in bits.
- REG_ADDR_W, 5, destination register index width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream has an operation.
- in_ready  output  1  stage can accept; registered, equals !skid_valid.
- alu_ctrl  input  riscv_pkg::alu_ops_t  operation from the ALU decoder.
- src_a  input  XLEN  operand A.
- src_b  input  XLEN  operand B (register or immediate, already muxed).
- rd_addr  input  REG_ADDR_W  destination register tag.
- reg_write  input  1  writeback enable tag.
- flush  input  1  kill all buffered and incoming operations.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts.
- alu_result  output  XLEN  computed result.
- out_rd_addr  output  REG_ADDR_W  tag passed through.
- out_reg_write  output  1  tag passed through.
- zero  output  1  alu_result == 0.

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, skid_valid=0, in_ready=1 from the next cycle. alu_result, out_rd_addr, out_reg_write and zero all read 0.
- Reset takes priority over every other input, including flush and an in-flight handshake.
- Accept when in_valid && in_ready. Output transfer when out_valid && out_ready.
- Operation is computed combinationally from the inputs and captured at accept. Latency is 1 cycle: an op accepted in cycle N is presented in cycle N+1 when the main register is free.
- Operations:
  - ADD: a+b mod 2^XLEN.
  - SUB: a-b mod 2^XLEN (a + ~b + 1).
  - AND, OR, XOR: bitwise.
  - Any other encoding: treated as ADD.
- zero is registered with the result, so it is never combinational on the output.
- Buffer states (the state machine):
  - EMPTY: out_valid=0, skid_valid=0.
  - ONE: out_valid=1, skid_valid=0.
  - TWO: out_valid=1, skid_valid=1.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept, no transfer -> TWO (new op lands in skid).
  - ONE + accept + transfer -> ONE (main register reloads with new op).
  - ONE + transfer, no accept -> EMPTY.
  - TWO + transfer -> ONE (skid moves to main register; no accept is possible since in_ready=0).
  - TWO, no transfer -> TWO (hold all values).
- While out_valid=1 and out_ready=0, alu_result, out_rd_addr, out_reg_write and zero are held stable.
- Ordering is strictly FIFO; no reordering and no drops except on flush.
- flush=1 (synchronous): next cycle is EMPTY with in_ready=1. An op presented with in_valid in the flush cycle is discarded, and any output transfer in that cycle still counts downstream.
- in_ready depends only on state, never on out_ready.

Optional Feature:
- Macro: ALU_EXEC_FLAGS_EN.
- Defined: adds three XLEN-independent 1-bit outputs, registered and buffered alongside the result:
  - carry: carry-out of ADD; for SUB it is the not-borrow, i.e. a >= b unsigned.
  - overflow: signed overflow of ADD/SUB; 0 for logic ops.
  - negative: alu_result[XLEN-1].
- Undefined: these ports and their storage are absent; all other behaviour is identical.

Decomposition:
- riscv_pkg holds alu_ops_t (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR) and an exec_payload_t struct (result, rd_addr, reg_write, zero, plus optional flags). The struct lets main and skid registers be single typed registers.
- One natural sub-module, alu_core: purely combinational, takes alu_ctrl, a and b, returns result and flags. It is instantiated once, ahead of the buffer.

Test Plan:
- Reset then ADD 0x7FFFFFFF+1 with out_ready=1 -> next cycle out_valid=1, alu_result=0x80000000, zero=0; with flags, overflow=1 and negative=1.
- SUB 5-5, rd=3, reg_write=1 -> alu_result=0, zero=1, out_rd_addr=3; with flags, carry=1.
- out_ready=0 while sending two ops (AND 0xF0F0&0xFF00, XOR 0xFF^0x0F) -> in_ready drops to 0 after the second accept; outputs hold 0xF000. Raise out_ready -> 0xF000 then 0xF0 on consecutive cycles, in_ready=1 again.
- TWO state, then assert flush with in_valid=1 (OR 1|2) -> next cycle out_valid=0, in_ready=1, and the OR never appears.
- rst asserted in ONE state with in_valid=1 -> next cycle out_valid=0, all outputs 0, nothing emitted afterwards.
- Back-to-back stream of 8 ADDs (i+i) with out_ready toggling every cycle -> results 0,2,…,14 emitted in order, none lost or duplicated.
